// File: rtl/switch_debouncer_if.sv
// Signal bundle between a bouncing switch source and its debouncer.
// The master drives the raw level and the slave returns the conditioned level and strobes.
interface switch_debouncer_if;
  logic din;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  modport master (output din, input q, rise, fall, busy);
  modport slave  (input din, output q, rise, fall, busy);
endinterface

// File: rtl/switch_debouncer.sv
// Debouncer: 2-flop synchronizer, stability counter and IDLE/CHECK FSM.
// Produces a clean level q plus one-cycle rise/fall strobes.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  switch_debouncer_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam logic             ONE_SHOT = (STABLE_CYCLES == 1);
  localparam logic [CNT_W:0]   STABLE_W = (CNT_W + 1)'(STABLE_CYCLES);

  state_t           state_r;
  logic             s1_r;
  logic             s2_r;
  logic             q_r;
  logic             rise_r;
  logic             fall_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W:0]   cnt_next_s;

  // One extra bit so the compare against STABLE_CYCLES can never overflow.
  assign cnt_next_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};

  // Synchronizer, stability counter and debounce FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      q_r     <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      state_r <= IDLE;
    end else begin
      s1_r   <= bus.din;
      s2_r   <= s1_r;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (s2_r == q_r) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (ONE_SHOT) begin
            q_r    <= ~q_r;
            rise_r <= ~q_r;
            fall_r <= q_r;
            cnt_r  <= {CNT_W{1'b0}};
          end else begin
            state_r <= CHECK;
            cnt_r   <= CNT_W'(1'b1);
          end
        end
        CHECK: begin
          if (s2_r == q_r) begin
            // Input fell back before it was stable long enough: a glitch.
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_next_s < STABLE_W) begin
            cnt_r <= cnt_next_s[CNT_W-1:0];
          end else begin
            q_r     <= ~q_r;
            rise_r  <= ~q_r;
            fall_r  <= q_r;
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.q    = q_r;
  assign bus.rise = rise_r;
  assign bus.fall = fall_r;
  assign bus.busy = (state_r == CHECK);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: default build and a STABLE_CYCLES=1 build.
module tb_switch_debouncer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  switch_debouncer_if bus0 ();
  switch_debouncer_if bus1 ();

  switch_debouncer #(.STABLE_CYCLES(4), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  switch_debouncer #(.STABLE_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {q, rise, fall, busy} of the default instance.
  task automatic test_reset();
    logic [3:0] obs;
    rst = 1'b1;
    bus0.din = 1'b1;
    bus1.din = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick();
      obs = {bus0.q, bus0.rise, bus0.fall, bus0.busy};
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset edge %0d: got %b want %b", e, obs, 4'b0000);
      end
    end
    rst = 1'b0;
    bus0.din = 1'b0;
    bus1.din = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      obs = {bus0.q, bus0.rise, bus0.fall, bus0.busy};
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle edge %0d: got %b want %b", e, obs, 4'b0000);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] obs;
    logic [3:0] exp;
    bus0.din = 1'b1;
    for (int e = 0; e < 8; e++) begin
      if (e == 2) bus0.din = 1'b0;
      tick();
      exp = {1'b0, 1'b0, 1'b0, (e == 2 || e == 3)};
      obs = {bus0.q, bus0.rise, bus0.fall, bus0.busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL glitch edge %0d: got %b want %b", e, obs, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] obs;
    logic [3:0] exp;
    bus0.din = 1'b1;
    for (int e = 0; e < 9; e++) begin
      tick();
      exp = {(e >= 5), (e == 5), 1'b0, (e >= 2 && e < 5)};
      obs = {bus0.q, bus0.rise, bus0.fall, bus0.busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL clean_press edge %0d: got %b want %b", e, obs, exp);
      end
    end
  endtask

  task automatic test_bouncing_release();
    logic [3:0] obs;
    logic [3:0] exp;
    for (int k = 0; k < 11; k++) begin
      bus0.din = (k == 0 || k == 2) ? 1'b1 : 1'b0;
      tick();
      exp = {(k < 8), 1'b0, (k == 8), (k == 3 || k == 5 || k == 6 || k == 7)};
      obs = {bus0.q, bus0.rise, bus0.fall, bus0.busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bounce_release edge %0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_check();
    logic [3:0] obs;
    logic [3:0] exp;
    bus0.din = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    checks++;
    if (bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL midchk_pre busy: got %b want %b", bus0.busy, 1'b1);
    end
    rst = 1'b1;
    tick();
    obs = {bus0.q, bus0.rise, bus0.fall, bus0.busy};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL midchk_reset: got %b want %b", obs, 4'b0000);
    end
    rst = 1'b0;
    for (int f = 0; f < 8; f++) begin
      tick();
      exp = {(f >= 5), (f == 5), 1'b0, (f >= 2 && f < 5)};
      obs = {bus0.q, bus0.rise, bus0.fall, bus0.busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL midchk_release edge %0d: got %b want %b", f, obs, exp);
      end
    end
    // q is now 1: reset must clear it without a fall strobe.
    rst = 1'b1;
    tick();
    obs = {bus0.q, bus0.rise, bus0.fall, bus0.busy};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_from_q1: got %b want %b", obs, 4'b0000);
    end
    rst = 1'b0;
    bus0.din = 1'b0;
    for (int e = 0; e < 3; e++) tick();
  endtask

  task automatic test_single_cycle_build();
    logic [3:0] obs;
    logic [3:0] exp;
    bus1.din = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      exp = {(e >= 2), (e == 2), 1'b0, 1'b0};
      obs = {bus1.q, bus1.rise, bus1.fall, bus1.busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_press edge %0d: got %b want %b", e, obs, exp);
      end
    end
    bus1.din = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      exp = {(e < 2), 1'b0, (e == 2), 1'b0};
      obs = {bus1.q, bus1.rise, bus1.fall, bus1.busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL single_release edge %0d: got %b want %b", e, obs, exp);
      end
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    bus0.din = 1'b0;
    bus1.din = 1'b0;
    test_reset();
    test_glitch();
    test_clean_press();
    test_bouncing_release();
    test_reset_mid_check();
    test_single_cycle_build();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
